// File: rtl/approx_mult_share_arb.sv
// Shares one 8x8 approximate multiplier among NREQ round-robin requesters; 2-stage pipe, tagged response.
// Optional macro APPROX_MULT_EXACT_BYPASS_EN adds a per-request exact-product bypass.
module approx_mult_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_x,
  input  logic [8*NREQ-1:0]    req_y,
`ifdef APPROX_MULT_EXACT_BYPASS_EN
  input  logic [NREQ-1:0]      req_exact,
  output logic                 resp_exact,
`endif
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [15:0]          resp_z,
  output logic [CNTW-1:0]      op_count
);

  // Truncated upper-nibble product plus OR/AND compensation of the dropped low nibble.
  function automatic logic [15:0] f_approx(input logic [7:0] x, input logic [7:0] y);
    logic [11:0] p;
    logic c0, c1, c2, c3, c4, c5;
    p  = {4'd0, y} * {8'd0, x[7:4]};
    c0 = (x[0] & y[7]) | (x[1] & y[6]);
    c1 = (x[2] & y[6]) | (x[3] & y[5]);
    c2 = (x[2] & y[5]) | (x[3] & y[4]);
    c3 = (x[2] & y[7]) | (x[3] & y[6]);
    c4 = (x[2] & y[7]) & (x[3] & y[6]);
    c5 = x[3] & y[7];
    return {p, 4'd0} + {7'd0, c0, 8'd0} + {7'd0, c1, 8'd0} + {7'd0, c2, 8'd0}
         + {6'd0, c3, 9'd0} + {5'd0, c4, 10'd0} + {5'd0, c5, 10'd0};
  endfunction

  logic [IDW-1:0]      r_ptr;
  logic                r_s1_vld, r_s2_vld;
  logic [7:0]          r_s1_x, r_s1_y;
  logic [IDW-1:0]      r_s1_id, r_s2_id;
  logic [15:0]         r_s2_z;
  logic [CNTW-1:0]     r_cnt;
  logic                r_s1_ex, r_s2_ex;

  logic [2*NREQ-1:0]   w_dbl;
  logic [NREQ-1:0]     w_rot;
  logic [IDW:0]        w_sum;
  logic [IDW-1:0]      w_win, w_ptr_nxt;
  logic                w_any, w_adv1, w_adv2, w_acc, w_ex;
  logic [7:0]          w_x, w_y;
  logic [15:0]         w_z;

  assign w_adv2 = !r_s2_vld | resp_ready;
  assign w_adv1 = !r_s1_vld | w_adv2;
  assign w_acc  = w_any & w_adv1 & !rst;

  // Rotate the request vector so bit 0 is the RR pointer; lowest set bit wins.
  always_comb begin
    w_dbl = {req_valid, req_valid} >> r_ptr;
    w_rot = w_dbl[NREQ-1:0];
    w_any = |w_rot;
    w_sum = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (w_rot[k]) w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
    if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
    w_win = w_sum[IDW-1:0];
  end

  assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + IDW'(1);

  always_comb begin
    req_ready = '0;
    w_x       = '0;
    w_y       = '0;
    w_ex      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        req_ready[i] = w_any & w_adv1 & !rst;
        w_x          = req_x[8*i +: 8];
        w_y          = req_y[8*i +: 8];
`ifdef APPROX_MULT_EXACT_BYPASS_EN
        w_ex         = req_exact[i];
`endif
      end
    end
  end

  always_comb begin
    w_z = f_approx(r_s1_x, r_s1_y);
`ifdef APPROX_MULT_EXACT_BYPASS_EN
    if (r_s1_ex) w_z = {8'd0, r_s1_x} * {8'd0, r_s1_y};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_s1_vld <= 1'b0;
      r_s1_x   <= '0;
      r_s1_y   <= '0;
      r_s1_id  <= '0;
      r_s1_ex  <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_z   <= '0;
      r_s2_id  <= '0;
      r_s2_ex  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_adv2) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_z  <= w_z;
          r_s2_id <= r_s1_id;
          r_s2_ex <= r_s1_ex;
        end
      end
      if (w_adv1) r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_x  <= w_x;
        r_s1_y  <= w_y;
        r_s1_id <= w_win;
        r_s1_ex <= w_ex;
        r_ptr   <= w_ptr_nxt;
        if (r_cnt != '1) r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign resp_valid = r_s2_vld;
  assign resp_id    = r_s2_id;
  assign resp_z     = r_s2_z;
  assign op_count   = r_cnt;
`ifdef APPROX_MULT_EXACT_BYPASS_EN
  assign resp_exact = r_s2_ex;
`endif

endmodule

// File: doc/approx_mult_share_arb.md
Name: approx_mult_share_arb

Overview:
- Shares one 8x8 unsigned approximate multiplier (l=4, truncated-low-nibble core with OR/AND compensation) between NREQ requesters.
- Round-robin arbiter in front, 2-stage pipeline (operand register, result register), tagged response bus with backpressure.
- Sits between accelerator lanes and a single multiplier instance to save area; also keeps a saturating op counter.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of the response tag (must satisfy 2**IDW >= NREQ).
- CNTW, 16, width of the saturating accepted-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_x  in  8*NREQ  multiplicand; requester i uses bits [8i+7:8i].
- req_y  in  8*NREQ  multiplier; requester i uses bits [8i+7:8i].
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of the requester that issued the result.
- resp_z  out  16  approximate product.
- op_count  out  CNTW  number of accepted requests, saturating at all-ones.

Behaviour:
- Reset (sync, active-high): resp_valid=0, resp_id=0, resp_z=0, op_count=0, both pipeline stages empty, RR pointer=0, req_ready=0 during the reset cycle.
- Arithmetic, z truncated to 16 bits: z = ((y*x[7:4])<<4) + 256*((x0&y7)|(x1&y6)) + 512*((x2&y7)|(x3&y6)) + 1024*((x2&y7)&(x3&y6)) + 256*((x2&y6)|(x3&y5)) + 1024*(x3&y7) + 256*((x2&y5)|(x3&y4)). Here xk/yk are bit k. The full-precision sum never exceeds 0xFFFF.
- Stages: S1 holds {x,y,id}. S2 holds {z,id} and drives resp_*. The product is computed combinationally from S1 and registered into S2.
- advance2 = !S2.valid | resp_ready.
- advance1 = !S1.valid | advance2.
- Arbitration is combinational. Candidates are the i with req_valid[i]. Winner = first candidate at or after the RR pointer, modulo NREQ. req_ready[winner] = advance1 and !rst; all other bits are 0.
- Accept = req_valid[w] & req_ready[w]. On accept: S1 loads the operands and id=w, the RR pointer becomes (w+1) mod NREQ, and op_count increments unless it is all-ones.
- With no accept, the pointer holds. S1 empties when it moves into S2 and nothing is accepted.
- Latency: accepted at edge t, result visible on resp_* after edge t+2 (2 cycles). Full throughput of 1 op/cycle while resp_ready=1.
- Stall (resp_valid & !resp_ready): S2 holds resp_z/resp_id stable. S1 holds if full. req_ready=0 when both stages are full.
- Requesters must hold x/y stable while req_valid=1 and not accepted. The block does not check this.
- Single requester asserting continuously gets every slot. All NREQ asserting get grants in strict rotation 0,1,..,NREQ-1.
- Reset mid-operation drops all in-flight results. No partial response is emitted.

Optional Feature:
- Macro: APPROX_MULT_EXACT_BYPASS_EN.
- When defined:
  - extra input req_exact (NREQ bits) is added, sampled with the operands into S1;
  - extra output resp_exact (1 bit) is added, reset 0;
  - requests with the exact bit set produce z = x*y (full 16-bit exact product) with the same 2-cycle latency; others use the approximate formula.
- When undefined: no extra ports, and all results are approximate.

Test Plan:
- Reset, then req0 x=0xFF,y=0xFF alone, resp_ready=1 -> accepted next edge; after 2 cycles resp_valid=1, resp_id=0, resp_z=0xFC10 (64528); op_count=1.
- req1 x=0x10,y=0x0A and req1 x=0x03,y=0x05 back-to-back -> resp_z=0x00A0 then 0x0000, consecutive cycles, resp_id=1 both.
- Both requesters valid continuously for 6 cycles, resp_ready=1 -> resp_id sequence 0,1,0,1,0,1; op_count=6.
- resp_ready=0 for 4 cycles with streaming requests -> resp_z/resp_id stable; exactly 2 results buffered; req_ready=0 once full; on release, results drain in order with none lost or duplicated.
- Assert rst with both stages full -> next cycle resp_valid=0, op_count=0, RR pointer=0; the first grant after reset goes to req0 when both request.
- With APPROX_MULT_EXACT_BYPASS_EN, req_exact=1, x=0xFF,y=0xFF -> resp_z=0xFE01, resp_exact=1; same operands with req_exact=0 -> 0xFC10.
